// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Brings the memory and core reset domains out of reset in order once the
//   PLL lock is qualified, waits for memory training, and flags a training
//   timeout. Any lock loss or soft-reset request restarts the sequence.
//
// Parameters
//   LOCK_FILTER_CYCLES : consecutive lock-high cycles needed to qualify lock (>=2)
//   HOLD_CYCLES        : cycles both resets stay asserted after lock qualifies (>=1)
//   TRAIN_TIMEOUT      : max cycles to wait for training done (>=2)
//
// Ports
//   i_clk           : clock, all logic on rising edge
//   i_reset         : synchronous active-high reset
//   i_pll_lock      : PLL lock, already synchronous to i_clk
//   i_soft_rst_req  : level soft-reset request
//   i_training_done : memory training complete, level
//   o_mem_rstn      : active-low memory-domain reset (high in WAIT_TRAIN/RUN)
//   o_core_rstn     : active-low core-domain reset (high in RUN)
//   o_fail          : training timeout flag (high in FAIL)
//   o_state         : current state encoding for debug
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int LOCK_FILTER_CYCLES = 16,
  parameter int HOLD_CYCLES        = 32,
  parameter int TRAIN_TIMEOUT      = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  input  logic       i_soft_rst_req,
  input  logic       i_training_done,
  output logic       o_mem_rstn,
  output logic       o_core_rstn,
  output logic       o_fail,
  output logic [2:0] o_state
);

  localparam int MAX_AB = (LOCK_FILTER_CYCLES > HOLD_CYCLES) ? LOCK_FILTER_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_AB > TRAIN_TIMEOUT) ? MAX_AB : TRAIN_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_TGT  = CNT_W'(LOCK_FILTER_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TGT  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TRAIN_TGT = CNT_W'(TRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_WAIT_TRAIN = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             mem_rstn_q, mem_rstn_d;
  logic             core_rstn_q, core_rstn_d;
  logic             fail_q, fail_d;

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RESET;
      cnt_q       <= CNT_ZERO;
      mem_rstn_q  <= 1'b0;
      core_rstn_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_rstn_q  <= mem_rstn_d;
      core_rstn_q <= core_rstn_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Saturating increment; compare against the targets using the value the
    // counter "would reach" this edge so each phase lasts exactly N cycles.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = CNT_ZERO;
      end
      ST_WAIT_LOCK: begin
        if (i_soft_rst_req || !i_pll_lock) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_inc == LOCK_TGT) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (i_soft_rst_req || !i_pll_lock) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc == HOLD_TGT) begin
          state_d = ST_WAIT_TRAIN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_TRAIN: begin
        if (i_soft_rst_req || !i_pll_lock) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (i_training_done) begin
          // Training completing on the timeout cycle still counts as success.
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc == TRAIN_TGT) begin
          state_d = ST_FAIL;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        cnt_d = CNT_ZERO;
        if (i_soft_rst_req || !i_pll_lock) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: begin
        // Sticky: lock activity is ignored, only a soft request leaves.
        cnt_d = CNT_ZERO;
        if (i_soft_rst_req) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the next state, registered so outputs track state_q.
  always_comb begin
    mem_rstn_d  = 1'b0;
    core_rstn_d = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      ST_WAIT_TRAIN: mem_rstn_d = 1'b1;
      ST_RUN: begin
        mem_rstn_d  = 1'b1;
        core_rstn_d = 1'b1;
      end
      ST_FAIL: fail_d = 1'b1;
      default: begin
        mem_rstn_d  = 1'b0;
        core_rstn_d = 1'b0;
        fail_d      = 1'b0;
      end
    endcase
  end

  assign o_mem_rstn  = mem_rstn_q;
  assign o_core_rstn = core_rstn_q;
  assign o_fail      = fail_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed testbench for reset_sequencer with default parameters. Inputs are
//   changed 1 time unit after each rising edge and outputs are sampled there,
//   so every observation reflects the registers updated by that edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       training_done;
  logic       mem_rstn;
  logic       core_rstn;
  logic       fail;
  logic [2:0] state;

  int total_cnt;
  int bad_cnt;

  logic [2:0] st_log   [0:70];
  logic       mem_log  [0:70];
  logic       core_log [0:70];

  reset_sequencer #(
    .LOCK_FILTER_CYCLES(16),
    .HOLD_CYCLES       (32),
    .TRAIN_TIMEOUT     (1024)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_pll_lock     (pll_lock),
    .i_soft_rst_req (soft_rst_req),
    .i_training_done(training_done),
    .o_mem_rstn     (mem_rstn),
    .o_core_rstn    (core_rstn),
    .o_fail         (fail),
    .o_state        (state)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt = total_cnt + 1;
    if (obs !== exp_v) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until o_state equals target; n is the edge count (limit if never).
  task automatic count_to(input logic [2:0] target, input int limit, output int n);
    n = 0;
    do begin
      step();
      n = n + 1;
    end while ((state !== target) && (n < limit));
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic m,
                            input logic c, input logic f);
    check_val({tag, "_state"}, 32'(state), 32'(st));
    check_val({tag, "_mem"},   32'(mem_rstn), 32'(m));
    check_val({tag, "_core"},  32'(core_rstn), 32'(c));
    check_val({tag, "_fail"},  32'(fail), 32'(f));
  endtask

  initial begin
    int n;
    int mem_rise;
    int core_rise;

    total_cnt     = 0;
    bad_cnt       = 0;
    reset         = 1'b1;
    pll_lock      = 1'b1;
    soft_rst_req  = 1'b0;
    training_done = 1'b0;

    // Reset values.
    step();
    step();
    check_outs("rst", 3'd0, 1'b0, 1'b0, 1'b0);

    // Nominal sequence: edge 1 is the first edge with reset low.
    reset = 1'b0;
    for (int e = 1; e <= 62; e++) begin
      if (e == 61) training_done = 1'b1;
      step();
      st_log[e]   = state;
      mem_log[e]  = mem_rstn;
      core_log[e] = core_rstn;
    end
    mem_rise  = 0;
    core_rise = 0;
    for (int e = 62; e >= 1; e--) begin
      if (mem_log[e] === 1'b1)  mem_rise  = e;
      if (core_log[e] === 1'b1) core_rise = e;
    end
    check_val("nom_mem_rise",  32'(mem_rise),  32'd49);
    check_val("nom_core_rise", 32'(core_rise), 32'd61);
    check_val("nom_st_e1",  32'(st_log[1]),  32'd1);
    check_val("nom_st_e16", 32'(st_log[16]), 32'd1);
    check_val("nom_st_e17", 32'(st_log[17]), 32'd2);
    check_val("nom_st_e48", 32'(st_log[48]), 32'd2);
    check_val("nom_st_e49", 32'(st_log[49]), 32'd3);
    check_val("nom_st_e60", 32'(st_log[60]), 32'd3);
    check_val("nom_st_e61", 32'(st_log[61]), 32'd4);

    // RUN does not depend on training_done after entry.
    training_done = 1'b0;
    repeat (5) step();
    check_outs("run_hold", 3'd4, 1'b1, 1'b1, 1'b0);

    // Lock lost in RUN, then full resequence.
    pll_lock = 1'b0;
    step();
    check_outs("lockloss", 3'd1, 1'b0, 1'b0, 1'b0);
    pll_lock = 1'b1;
    count_to(3'd2, 100, n);
    check_val("relock_to_hold", 32'(n), 32'd16);
    count_to(3'd3, 100, n);
    check_val("relock_to_train", 32'(n), 32'd32);
    check_val("relock_mem", 32'(mem_rstn), 32'd1);
    training_done = 1'b1;
    step();
    check_outs("relock_run", 3'd4, 1'b1, 1'b1, 1'b0);
    training_done = 1'b0;

    // One-cycle reset pulse in RUN.
    reset = 1'b1;
    step();
    check_outs("midrst", 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_val("midrst_e1", 32'(state), 32'd1);

    // Lock glitch at WAIT_LOCK count 10.
    repeat (10) step();
    check_val("glitch_pre", 32'(state), 32'd1);
    pll_lock = 1'b0;
    step();
    check_val("glitch_stay", 32'(state), 32'd1);
    pll_lock = 1'b1;
    count_to(3'd2, 100, n);
    check_val("glitch_to_hold", 32'(n), 32'd16);
    count_to(3'd3, 100, n);
    check_val("glitch_to_train", 32'(n), 32'd32);

    // Training never done: timeout after exactly 1024 cycles.
    count_to(3'd5, 1100, n);
    check_val("timeout_cycles", 32'(n), 32'd1024);
    check_outs("fail", 3'd5, 1'b0, 1'b0, 1'b1);

    // FAIL is sticky through lock toggles.
    for (int k = 0; k < 4; k++) begin
      pll_lock = ~pll_lock;
      step();
      check_outs("fail_sticky", 3'd5, 1'b0, 1'b0, 1'b1);
    end
    pll_lock = 1'b1;

    // Soft request exits FAIL and holds WAIT_LOCK while high.
    soft_rst_req = 1'b1;
    step();
    check_outs("soft_exit", 3'd1, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    check_val("soft_held", 32'(state), 32'd1);
    soft_rst_req = 1'b0;
    count_to(3'd2, 100, n);
    check_val("soft_to_hold", 32'(n), 32'd16);
    count_to(3'd3, 100, n);
    check_val("soft_to_train", 32'(n), 32'd32);

    // Training done on the same cycle the timeout expires: RUN wins.
    repeat (1023) step();
    check_val("tie_pre", 32'(state), 32'd3);
    training_done = 1'b1;
    step();
    check_outs("tie_run", 3'd4, 1'b1, 1'b1, 1'b0);
    training_done = 1'b0;

    // Soft request in RUN drops both resets.
    soft_rst_req = 1'b1;
    step();
    check_outs("soft_run", 3'd1, 1'b0, 1'b0, 1'b0);
    soft_rst_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
